// File: rtl/multizone_thermostat.sv
// Per-zone heat/cool hysteresis controller with minimum dwell time in active states.
// Optional sticky sensor-fault detection enabled by defining THERMO_FAULT_EN.
module multizone_thermostat #(
  parameter int unsigned ZONES     = 2,
  parameter int unsigned TEMP_W    = 5,
  parameter int unsigned HEAT_ON   = 18,
  parameter int unsigned HEAT_OFF  = 20,
  parameter int unsigned COOL_ON   = 22,
  parameter int unsigned COOL_OFF  = 20,
  parameter int unsigned MIN_DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ZONES*TEMP_W-1:0] temp,
  input  logic [ZONES-1:0]        temp_valid,
  input  logic [ZONES-1:0]        zone_en,
  input  logic                    fault_clr,
  output logic [ZONES-1:0]        heating,
  output logic [ZONES-1:0]        cooling,
  output logic [ZONES-1:0]        fault
);

  localparam int unsigned DW_W = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HEATING = 2'd1;
  localparam logic [1:0] COOLING = 2'd2;

  // Threshold ordering must leave a non-empty band between heating and cooling.
  if (!(HEAT_ON < HEAT_OFF && HEAT_OFF <= COOL_OFF && COOL_OFF < COOL_ON &&
        64'(COOL_ON) < (64'd1 << TEMP_W) && ZONES >= 1 && ZONES <= 8)) begin : g_param_check
    $fatal(1, "multizone_thermostat: illegal parameter set");
  end

  logic [1:0]      state_q [ZONES];
  logic [1:0]      state_d [ZONES];
  logic [DW_W-1:0] cnt_q   [ZONES];
  logic [DW_W-1:0] cnt_d   [ZONES];
  logic [ZONES-1:0] heat_d;
  logic [ZONES-1:0] cool_d;
  logic [ZONES-1:0] flt;

`ifdef THERMO_FAULT_EN
  logic [ZONES-1:0] fault_q;
  logic [ZONES-1:0] fault_d;
  logic [ZONES-1:0] bad;

  // A rail-value sample from an enabled zone is treated as a broken sensor.
  always_comb begin
    bad = '0;
    for (int z = 0; z < ZONES; z++) begin
      bad[z] = temp_valid[z] && zone_en[z] &&
               ((temp[z*TEMP_W +: TEMP_W] == '0) || (temp[z*TEMP_W +: TEMP_W] == '1));
    end
    fault_d = (fault_q & ~{ZONES{fault_clr}}) | bad;
    flt     = fault_q | bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= '0;
    else        fault_q <= fault_d;
  end

  assign fault = fault_q;
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
  assign flt   = '0;
  assign fault = '0;
`endif

  // Next-state and next-output decode for every zone.
  always_comb begin
    for (int z = 0; z < ZONES; z++) begin
      logic [TEMP_W-1:0] t;
      logic              v;
      logic              sat;
      t   = temp[z*TEMP_W +: TEMP_W];
      v   = temp_valid[z];
      sat = (cnt_q[z] == DW_W'(MIN_DWELL));

      state_d[z] = state_q[z];
      cnt_d[z]   = sat ? cnt_q[z] : cnt_q[z] + DW_W'(1);

      if (!zone_en[z] || flt[z]) begin
        state_d[z] = IDLE;
        cnt_d[z]   = '0;
      end else begin
        case (state_q[z])
          IDLE: begin
            cnt_d[z] = '0;
            if (v && t <= TEMP_W'(HEAT_ON))      state_d[z] = HEATING;
            else if (v && t >= TEMP_W'(COOL_ON)) state_d[z] = COOLING;
          end
          HEATING: begin
            if (v && t >= TEMP_W'(HEAT_OFF) && sat) begin
              state_d[z] = IDLE;
              cnt_d[z]   = '0;
            end
          end
          COOLING: begin
            if (v && t <= TEMP_W'(COOL_OFF) && sat) begin
              state_d[z] = IDLE;
              cnt_d[z]   = '0;
            end
          end
          default: begin
            state_d[z] = IDLE;
            cnt_d[z]   = '0;
          end
        endcase
      end

      heat_d[z] = (state_d[z] == HEATING);
      cool_d[z] = (state_d[z] == COOLING);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int z = 0; z < ZONES; z++) begin
        state_q[z] <= IDLE;
        cnt_q[z]   <= '0;
      end
      heating <= '0;
      cooling <= '0;
    end else begin
      for (int z = 0; z < ZONES; z++) begin
        state_q[z] <= state_d[z];
        cnt_q[z]   <= cnt_d[z];
      end
      heating <= heat_d;
      cooling <= cool_d;
    end
  end

endmodule

// File: tb/tb_multizone_thermostat.sv
// Directed bench for multizone_thermostat at default parameters (2 zones, 5-bit temps, dwell 4).
module tb_multizone_thermostat;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] temp;
  logic [1:0] temp_valid;
  logic [1:0] zone_en;
  logic       fault_clr;
  logic [1:0] heating;
  logic [1:0] cooling;
  logic [1:0] fault;

  int checks = 0;
  int errors = 0;

  multizone_thermostat dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .temp       (temp),
    .temp_valid (temp_valid),
    .zone_en    (zone_en),
    .fault_clr  (fault_clr),
    .heating    (heating),
    .cooling    (cooling),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [1:0] h, input logic [1:0] c, input logic [1:0] f);
    chk({tag, ".heating"}, heating, h);
    chk({tag, ".cooling"}, cooling, c);
    chk({tag, ".fault"},   fault,   f);
    chk({tag, ".both"},    heating & cooling, 2'b00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] t1, input logic v1, input logic [4:0] t0, input logic v0);
    temp       = {t1, t0};
    temp_valid = {v1, v0};
  endtask

  initial begin
    rst_n      = 1'b0;
    zone_en    = 2'b11;
    fault_clr  = 1'b0;
    drive(5'd0, 1'b0, 5'd0, 1'b0);
    #3;
    outs("reset", 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Zone0 heating cycle with dwell
    drive(5'd0, 1'b0, 5'd20, 1'b1); tick();
    outs("z0_idle20", 2'b00, 2'b00, 2'b00);
    drive(5'd0, 1'b0, 5'd18, 1'b1); tick();
    outs("z0_heat18", 2'b01, 2'b00, 2'b00);
    drive(5'd0, 1'b0, 5'd19, 1'b1); tick();
    outs("z0_hold19", 2'b01, 2'b00, 2'b00);
    drive(5'd0, 1'b0, 5'd20, 1'b1); tick();
    outs("z0_dwell_ignore", 2'b01, 2'b00, 2'b00);
    drive(5'd0, 1'b0, 5'd0, 1'b0); tick(); tick();
    outs("z0_no_latch", 2'b01, 2'b00, 2'b00);
    drive(5'd0, 1'b0, 5'd20, 1'b1); tick();
    outs("z0_exit20", 2'b00, 2'b00, 2'b00);

    // Boundaries from IDLE: 19 and 21 both hold
    drive(5'd21, 1'b1, 5'd19, 1'b1); tick();
    outs("idle_band", 2'b00, 2'b00, 2'b00);

    // Zone1 heating, early exit sample ignored, then IDLE before COOLING
    drive(5'd10, 1'b1, 5'd0, 1'b0); tick();
    outs("z1_heat", 2'b10, 2'b00, 2'b00);
    drive(5'd0, 1'b0, 5'd0, 1'b0); tick();
    drive(5'd25, 1'b1, 5'd0, 1'b0); tick();
    outs("z1_dwell25", 2'b10, 2'b00, 2'b00);
    drive(5'd0, 1'b0, 5'd0, 1'b0); tick(); tick();
    drive(5'd25, 1'b1, 5'd0, 1'b0); tick();
    outs("z1_to_idle", 2'b00, 2'b00, 2'b00);
    tick();
    outs("z1_cool", 2'b00, 2'b10, 2'b00);

    // Zone0 cooling at COOL_ON boundary, then disabled
    drive(5'd0, 1'b0, 5'd22, 1'b1); tick();
    outs("z0_cool22", 2'b00, 2'b11, 2'b00);
    zone_en = 2'b10; tick();
    outs("z0_disable", 2'b00, 2'b10, 2'b00);
    drive(5'd0, 1'b0, 5'd18, 1'b1); tick();
    outs("z0_disabled_ignore", 2'b00, 2'b10, 2'b00);
    zone_en = 2'b11;

    // Async reset between edges with both zones active
    drive(5'd0, 1'b0, 5'd18, 1'b1); tick();
    outs("pre_reset", 2'b01, 2'b10, 2'b00);
    drive(5'd0, 1'b0, 5'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1 outs("async_reset", 2'b00, 2'b00, 2'b00);
    #2 rst_n = 1'b1;
    drive(5'd20, 1'b1, 5'd0, 1'b0); tick();
    outs("post_reset_idle", 2'b00, 2'b00, 2'b00);

    // Zone1 heating then an all-ones sample once dwell is satisfied
    drive(5'd18, 1'b1, 5'd0, 1'b0); tick();
    outs("z1_heat18", 2'b10, 2'b00, 2'b00);
    drive(5'd0, 1'b0, 5'd0, 1'b0); tick(); tick(); tick(); tick();
    drive(5'd31, 1'b1, 5'd0, 1'b0); tick();
`ifdef THERMO_FAULT_EN
    outs("z1_fault31", 2'b00, 2'b00, 2'b10);
    tick();
    outs("z1_fault_hold", 2'b00, 2'b00, 2'b10);
    drive(5'd31, 1'b1, 5'd0, 1'b0); fault_clr = 1'b1; tick();
    outs("z1_clr_vs_new", 2'b00, 2'b00, 2'b10);
    drive(5'd0, 1'b0, 5'd0, 1'b0); tick();
    outs("z1_clr", 2'b00, 2'b00, 2'b00);
    fault_clr = 1'b0;
`else
    outs("z1_exit31", 2'b00, 2'b00, 2'b00);
    tick();
    outs("z1_cool31", 2'b00, 2'b10, 2'b00);
    drive(5'd0, 1'b0, 5'd0, 1'b0); fault_clr = 1'b1; tick();
    outs("z1_clr_ignored", 2'b00, 2'b10, 2'b00);
    fault_clr = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
